obstacle_fetch: RTL and testbench

//  Avalon-MM read master for the 1024x32 obstacle sprite on-chip RAM slave.

---
 rtl/obstacle_fetch_if.sv | 30 +++
 rtl/obstacle_fetch.sv | 161 ++++++++++++++++
 tb/tb_obstacle_fetch.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_fetch_if.sv
// Avalon-MM read bus between the obstacle fetch master and the sprite RAM.
//   address    master->slave  word address
//   clken      master->slave  slave clock enable
//   chipselect master->slave  read strobe, one word per asserted cycle
//   write      master->slave  write enable (tied low by the read master)
//   writedata  master->slave  write data (tied low by the read master)
//   byteenable master->slave  byte lanes
//   readdata   slave->master  read data, valid a fixed latency after the strobe
interface obstacle_fetch_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              clken;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [3:0]        byteenable;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, clken, chipselect, write, writedata, byteenable,
    input  readdata
  );

  modport slave (
    input  address, clken, chipselect, write, writedata, byteenable,
    output readdata
  );
endinterface

// File: rtl/obstacle_fetch.sv
// Burst read master for the obstacle sprite RAM.
// Takes a (base address, length) command, reads the words in order over a
// fixed-latency Avalon-MM slave and streams them out through a valid/ready
// port backed by a small FIFO. Strobes are only issued when a FIFO slot is
// guaranteed, so back-pressure never drops a word.
// Ports:
//   clk_clk, reset_reset      clock, synchronous active-high reset
//   cmd_valid/ready/addr/len  burst command handshake
//   m                         Avalon-MM read master bus
//   out_valid/ready/data/last word stream to the renderer
//   busy                      command in progress
//   done                      one-cycle pulse when a command completes
module obstacle_fetch #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LEN_W        = 11,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  obstacle_fetch_if.master  m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        remain_q, remain_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0] pipe_last_q, pipe_last_d;
  logic [DATA_W-1:0]       fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]       fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last_q, fifo_last_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        inflight;
  logic                    strobe, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: every word already strobed but not yet popped owns a FIFO slot,
  // so a pop in this cycle is deliberately not counted as free space.
  assign inflight  = CNT_W'($countones(pipe_vld_q));
  assign strobe    = (state_q == ISSUE) && ((count_q + inflight) < CNT_W'(FIFO_DEPTH));
  assign push      = pipe_vld_q[READ_LATENCY-1];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  assign m.address    = addr_q;
  assign m.chipselect = strobe;
  assign m.clken      = 1'b1;
  assign m.write      = 1'b0;
  assign m.writedata  = '0;
  assign m.byteenable = 4'hF;

  // Sequencer
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          if (cmd_len != '0) state_d = ISSUE;
          else               done_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (strobe) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-return pipe and FIFO; the shift drops the oldest stage off the top.
  always_comb begin
    pipe_vld_d  = READ_LATENCY'({pipe_vld_q, strobe});
    pipe_last_d = READ_LATENCY'({pipe_last_q, strobe && (remain_q == LEN_W'(1))});
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = m.readdata;
      fifo_last_d[wr_ptr_q] = pipe_last_q[READ_LATENCY-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      done_q      <= done_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk_clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_last_q <= fifo_last_d;
  end
endmodule

// File: tb/tb_obstacle_fetch.sv
module tb_obstacle_fetch;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic          a_cmd_valid = 1'b0, a_cmd_ready;
  logic [AW-1:0] a_cmd_addr = '0;
  logic [LW-1:0] a_cmd_len = '0;
  logic          a_out_valid, a_out_ready = 1'b0, a_out_last, a_busy, a_done;
  logic [DW-1:0] a_out_data;

  logic          b_cmd_valid = 1'b0, b_cmd_ready;
  logic [AW-1:0] b_cmd_addr = '0;
  logic [LW-1:0] b_cmd_len = '0;
  logic          b_out_valid, b_out_ready = 1'b0, b_out_last, b_busy, b_done;
  logic [DW-1:0] b_out_data;

  obstacle_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) a_m ();
  obstacle_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) b_m ();

  obstacle_fetch #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk_clk(clk), .reset_reset(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_addr(a_cmd_addr), .cmd_len(a_cmd_len),
    .m(a_m),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .busy(a_busy), .done(a_done)
  );

  obstacle_fetch #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .READ_LATENCY(2), .FIFO_DEPTH(4)) u_dut_b (
    .clk_clk(clk), .reset_reset(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len),
    .m(b_m),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .busy(b_busy), .done(b_done)
  );

  function automatic logic [DW-1:0] a_word(input logic [AW-1:0] ad);
    return DW'(ad) * 32'd3;
  endfunction

  function automatic logic [DW-1:0] b_word(input logic [AW-1:0] ad);
    return DW'(ad) * 32'd7 + 32'h1000;
  endfunction

  // Slave RAM models: latency 1 for A, latency 2 for B; junk when not strobed.
  logic [DW-1:0] b_p1;
  always @(posedge clk) begin
    a_m.readdata <= a_m.chipselect ? a_word(a_m.address) : 32'hDEAD_BEEF;
    b_p1         <= b_m.chipselect ? b_word(b_m.address) : 32'hDEAD_BEEF;
    b_m.readdata <= b_p1;
  end

  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t a_e, b_e;
  int n_cmp = 0;
  int n_err = 0;
  logic          a_hold_prev = 1'b0, b_hold_prev = 1'b0;
  logic [DW:0]   a_prev_head, b_prev_head;

  // Scoreboard monitors: every accepted beat must be the next expected word,
  // and a stalled head must not change.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_err++;
        $display("FAIL a_beat: got data=%h last=%b, expected no beat", a_out_data, a_out_last);
      end else begin
        a_e = q_a.pop_front();
        if (a_out_data !== a_e.d || a_out_last !== a_e.l) begin
          n_err++;
          $display("FAIL a_beat: got data=%h last=%b, expected data=%h last=%b",
                   a_out_data, a_out_last, a_e.d, a_e.l);
        end
      end
    end
    if (a_hold_prev && a_out_valid) begin
      n_cmp++;
      if ({a_out_data, a_out_last} !== a_prev_head) begin
        n_err++;
        $display("FAIL a_hold: got %h, expected %h", {a_out_data, a_out_last}, a_prev_head);
      end
    end
    a_hold_prev = a_out_valid && !a_out_ready;
    a_prev_head = {a_out_data, a_out_last};
  end

  always @(negedge clk) begin
    if (b_out_valid && b_out_ready) begin
      n_cmp++;
      if (q_b.size() == 0) begin
        n_err++;
        $display("FAIL b_beat: got data=%h last=%b, expected no beat", b_out_data, b_out_last);
      end else begin
        b_e = q_b.pop_front();
        if (b_out_data !== b_e.d || b_out_last !== b_e.l) begin
          n_err++;
          $display("FAIL b_beat: got data=%h last=%b, expected data=%h last=%b",
                   b_out_data, b_out_last, b_e.d, b_e.l);
        end
      end
    end
    if (b_hold_prev && b_out_valid) begin
      n_cmp++;
      if ({b_out_data, b_out_last} !== b_prev_head) begin
        n_err++;
        $display("FAIL b_hold: got %h, expected %h", {b_out_data, b_out_last}, b_prev_head);
      end
    end
    b_hold_prev = b_out_valid && !b_out_ready;
    b_prev_head = {b_out_data, b_out_last};
  end

  task automatic push_a(input int addr, input int len);
    for (int k = 0; k < len; k++) q_a.push_back('{d: a_word(AW'(addr + k)), l: (k == len - 1)});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a_cmd_ready, a_m.chipselect, a_m.address, a_out_valid, a_out_last, a_busy, a_done}
        !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b cs=%b addr=%0d ov=%b ol=%b busy=%b done=%b, expected 1 0 0 0 0 0 0",
               a_cmd_ready, a_m.chipselect, a_m.address, a_out_valid, a_out_last, a_busy, a_done);
    end
    n_cmp++;
    if ({a_m.clken, a_m.write, a_m.writedata, a_m.byteenable} !== {1'b1, 1'b0, 32'd0, 4'hF}) begin
      n_err++;
      $display("FAIL reset_consts: got clken=%b wr=%b wd=%h be=%h, expected 1 0 0 f",
               a_m.clken, a_m.write, a_m.writedata, a_m.byteenable);
    end
    n_cmp++;
    if ({b_cmd_ready, b_m.chipselect, b_out_valid, b_busy, b_done} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_b: got %b, expected 10000",
               {b_cmd_ready, b_m.chipselect, b_out_valid, b_busy, b_done});
    end
  endtask

  task automatic test_burst;
    int first_v = -1, beats = 0, last_pop = -1, done_cnt = 0, done_cyc = -1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      a_cmd_valid = (c == 0);
      a_cmd_addr  = AW'(5);
      a_cmd_len   = LW'(8);
      if (c == 0) push_a(5, 8);
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (a_cmd_ready !== 1'b1) begin n_err++; $display("FAIL burst_accept: got cmd_ready=%b, expected 1", a_cmd_ready); end
      end
      if (c == 1) begin
        n_cmp++;
        if ({a_m.chipselect, a_busy, a_m.address} !== {1'b1, 1'b1, 10'd5}) begin
          n_err++;
          $display("FAIL burst_strobe1: got cs=%b busy=%b addr=%0d, expected 1 1 5", a_m.chipselect, a_busy, a_m.address);
        end
      end
      if (a_out_valid && first_v < 0) first_v = c;
      if (a_out_valid && a_out_ready) begin
        beats++;
        if (a_out_last) last_pop = c;
      end
      if (a_done) begin
        done_cnt++;
        done_cyc = c;
        n_cmp++;
        if ({a_busy, a_cmd_ready} !== 2'b01) begin
          n_err++;
          $display("FAIL burst_done_flags: got busy=%b cmd_ready=%b, expected 0 1", a_busy, a_cmd_ready);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (first_v != 3) begin n_err++; $display("FAIL burst_first_valid: got cycle %0d, expected 3", first_v); end
    n_cmp++;
    if (beats != 8 || last_pop - first_v != 7) begin
      n_err++;
      $display("FAIL burst_beats: got %0d beats last@%0d, expected 8 consecutive from 3", beats, last_pop);
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != last_pop + 1) begin
      n_err++;
      $display("FAIL burst_done: got %0d pulses @%0d, expected 1 @%0d", done_cnt, done_cyc, last_pop + 1);
    end
    n_cmp++;
    if (q_a.size() != 0) begin n_err++; $display("FAIL burst_left: got %0d unread, expected 0", q_a.size()); end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] seen[$];
    logic [AW-1:0] exp_ad;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 14; c++) begin
      a_cmd_valid = (c == 0);
      a_cmd_addr  = AW'(1022);
      a_cmd_len   = LW'(4);
      if (c == 0) push_a(1022, 4);
      @(negedge clk);
      if (a_m.chipselect) seen.push_back(a_m.address);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen.size() != 4) begin n_err++; $display("FAIL wrap_strobes: got %0d, expected 4", seen.size()); end
    for (int k = 0; k < seen.size() && k < 4; k++) begin
      exp_ad = AW'(1022 + k);
      n_cmp++;
      if (seen[k] !== exp_ad) begin n_err++; $display("FAIL wrap_addr%0d: got %0d, expected %0d", k, seen[k], exp_ad); end
    end
    n_cmp++;
    if (q_a.size() != 0) begin n_err++; $display("FAIL wrap_left: got %0d unread, expected 0", q_a.size()); end
  endtask

  task automatic test_backpressure;
    int st = 0, pp = 0, max_occ = 0, occ20 = -1;
    bit got_done = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 80 && !got_done; c++) begin
      a_cmd_valid = (c == 0);
      a_cmd_addr  = AW'(100);
      a_cmd_len   = LW'(16);
      a_out_ready = !(c >= 4 && c <= 20);
      if (c == 0) push_a(100, 16);
      @(negedge clk);
      if (a_m.chipselect) st++;
      if (a_out_valid && a_out_ready) pp++;
      if (st - pp > max_occ) max_occ = st - pp;
      if (c == 20) occ20 = st - pp;
      if (a_done) got_done = 1;
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    n_cmp++;
    if (max_occ > 4) begin n_err++; $display("FAIL bp_occupancy: got %0d outstanding, expected <= 4", max_occ); end
    n_cmp++;
    if (occ20 != 4) begin n_err++; $display("FAIL bp_pause: got %0d outstanding while stalled, expected 4", occ20); end
    n_cmp++;
    if (!got_done || pp != 16) begin n_err++; $display("FAIL bp_complete: got done=%0d pops=%0d, expected 1 16", got_done, pp); end
    n_cmp++;
    if (q_a.size() != 0) begin n_err++; $display("FAIL bp_left: got %0d unread, expected 0", q_a.size()); end
  endtask

  task automatic test_zero_len;
    int cs_cnt = 0, done_cnt = 0, done_cyc = -1, busy_cnt = 0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      a_cmd_valid = (c == 0);
      a_cmd_addr  = AW'(7);
      a_cmd_len   = LW'(0);
      @(negedge clk);
      if (a_m.chipselect) cs_cnt++;
      if (a_busy) busy_cnt++;
      if (a_done) begin done_cnt++; done_cyc = c; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cs_cnt != 0 || busy_cnt != 0) begin n_err++; $display("FAIL zero_strobe: got cs=%0d busy=%0d cycles, expected 0 0", cs_cnt, busy_cnt); end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != 1) begin n_err++; $display("FAIL zero_done: got %0d pulses @%0d, expected 1 @1", done_cnt, done_cyc); end
  endtask

  task automatic test_reset_mid;
    int pp = 0, done_cnt = 0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 60 && pp < 10; c++) begin
      a_cmd_valid = (c == 0);
      a_cmd_addr  = AW'(200);
      a_cmd_len   = LW'(32);
      if (c == 0) push_a(200, 32);
      @(negedge clk);
      if (a_out_valid && a_out_ready) pp++;
      if (pp < 10) begin @(posedge clk); #1; end
    end
    a_cmd_valid = 1'b0;
    n_cmp++;
    if (pp < 10) begin n_err++; $display("FAIL rmid_progress: got %0d pops, expected 10", pp); end
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.delete();
    @(negedge clk);
    n_cmp++;
    if ({a_cmd_ready, a_m.chipselect, a_m.address, a_out_valid, a_out_last, a_busy, a_done}
        !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rmid_reset_state: got rdy=%b cs=%b addr=%0d ov=%b ol=%b busy=%b done=%b, expected 1 0 0 0 0 0 0",
               a_cmd_ready, a_m.chipselect, a_m.address, a_out_valid, a_out_last, a_busy, a_done);
    end
    pp = 0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 12; c++) begin
      a_cmd_valid = (c == 0);
      a_cmd_addr  = AW'(0);
      a_cmd_len   = LW'(2);
      if (c == 0) push_a(0, 2);
      @(negedge clk);
      if (a_out_valid && a_out_ready) pp++;
      if (a_done) done_cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (pp != 2 || done_cnt != 1) begin n_err++; $display("FAIL rmid_new_cmd: got pops=%0d done=%0d, expected 2 1", pp, done_cnt); end
    n_cmp++;
    if (q_a.size() != 0) begin n_err++; $display("FAIL rmid_left: got %0d unread, expected 0", q_a.size()); end
  endtask

  task automatic test_latency2_random;
    int st, pp, max_occ, addr, len;
    bit got_done;
    max_occ = 0;
    for (int n = 0; n < 4; n++) begin
      addr = (n == 0) ? 1010 : int'($urandom_range(0, 1023));
      len  = int'($urandom_range(1, 40));
      st = 0; pp = 0; got_done = 0;
      @(posedge clk); #1;
      for (int c = 0; c < 400 && !got_done; c++) begin
        b_cmd_valid = (c == 0);
        b_cmd_addr  = AW'(addr);
        b_cmd_len   = LW'(len);
        b_out_ready = ($urandom_range(0, 2) != 0);
        if (c == 0)
          for (int k = 0; k < len; k++) q_b.push_back('{d: b_word(AW'(addr + k)), l: (k == len - 1)});
        @(negedge clk);
        if (b_m.chipselect) st++;
        if (b_out_valid && b_out_ready) pp++;
        if (st - pp > max_occ) max_occ = st - pp;
        if (b_done) got_done = 1;
        @(posedge clk); #1;
      end
      b_cmd_valid = 1'b0;
      n_cmp++;
      if (!got_done || pp != len) begin
        n_err++;
        $display("FAIL l2_cmd%0d: got done=%0d pops=%0d, expected 1 %0d", n, got_done, pp, len);
      end
    end
    n_cmp++;
    if (max_occ > 4) begin n_err++; $display("FAIL l2_occupancy: got %0d outstanding, expected <= 4", max_occ); end
    n_cmp++;
    if (q_b.size() != 0) begin n_err++; $display("FAIL l2_left: got %0d unread, expected 0", q_b.size()); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_burst();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_latency2_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
